serial_adder_ctrl: RTL and testbench

//  Bit-serial add controller. Time-shares one 1-bit adder slice (two half_adder

---
 rtl/serial_adder_ctrl.sv | 161 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add controller: one shared 1-bit slice (two half adders + OR) walks
// WIDTH operand bits LSB first. Optional subtract mode under macro SUB_EN.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SUB_EN
  input  logic             sub,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             slice_s0, slice_c0, slice_s, slice_c1, slice_c;
  logic [WIDTH-1:0] b_load;
  logic             carry_init;

`ifdef SUB_EN
  // Subtraction as A + ~B + 1: invert B on load and seed the carry.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  half_adder u_ha0 (.a(a_sr_q[0]), .b(b_sr_q[0]), .s(slice_s0), .c(slice_c0));
  half_adder u_ha1 (.a(slice_s0),  .b(carry_q),   .s(slice_s),  .c(slice_c1));
  assign slice_c = slice_c0 | slice_c1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
        else       state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_q == LAST_BIT) state_d = ST_DONE;
        else                   state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_RUN:  busy  = 1'b1;
      ST_DONE: done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath next values: load on accepted start, shift one bit per RUN cycle
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b_load;
          carry_d = carry_init;
          cnt_d   = {CW{1'b0}};
        end else begin
          a_sr_d  = a_sr_q;
        end
      end
      ST_RUN: begin
        sum_d   = {slice_s, sum_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) cout_d = slice_c;
        else                   cout_d = cout_q;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_q  <= {WIDTH{1'b0}};
      b_sr_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8); define SUB_EN
// to also exercise the subtract mode.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         sub_i = 1'b0;
  logic         ready, busy, done, cout;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a_i),
    .b     (b_i),
`ifdef SUB_EN
    .sub   (sub_i),
`endif
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) from the negedge after acceptance until done is seen.
  task automatic wait_done(output int cyc, output int nbusy);
    cyc = 0;
    nbusy = 0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1 && ready === 1'b0) nbusy++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic sv, input logic [W-1:0] exp_s, input logic exp_c);
    int cyc, nbusy;
    @(negedge clk);
    a_i = av; b_i = bv; sub_i = sv; start = 1'b1;
    check({tag, "_ready_pre"}, 32'(ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    a_i = W'($urandom); b_i = W'($urandom); sub_i = ~sv;
    wait_done(cyc, nbusy);
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_sum"}, 32'(sum), 32'(exp_s));
    check({tag, "_cout"}, 32'(cout), 32'(exp_c));
    check({tag, "_ready_in_done"}, 32'(ready), 32'd0);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int cyc, nbusy, bad, ndone;
    logic [W-1:0] held_sum;
    logic held_cout;

    // Reset state
    #2;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic adds and carry boundaries
    do_op("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("add_ff_ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1);
    do_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    do_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    do_op("add_a5_5a", 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0);

    // Start held during RUN with new operands, then back-to-back accept
    @(negedge clk);
    a_i = 8'h11; b_i = 8'h22; sub_i = 1'b0; start = 1'b1;
    @(negedge clk);
    a_i = 8'hAA; b_i = 8'h54;
    wait_done(cyc, nbusy);
    check("hold_latency", 32'(cyc), 32'd8);
    check("hold_sum", 32'(sum), 32'h33);
    check("hold_cout", 32'(cout), 32'd0);
    @(negedge clk);
    check("b2b_ready", 32'(ready), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(cyc, nbusy);
    check("b2b_latency", 32'(cyc), 32'd8);
    check("b2b_sum", 32'(sum), 32'hFE);
    check("b2b_cout", 32'(cout), 32'd0);
    @(negedge clk);

    // Reset asserted mid-RUN after four bits
    @(negedge clk);
    a_i = 8'h3C; b_i = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("mid_rst_no_done", 32'(ndone), 32'd0);
    do_op("post_rst_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

    // Result holds across idle cycles with wiggling operands
    do_op("hold_pre_c3_7e", 8'hC3, 8'h7E, 1'b0, 8'h41, 1'b1);
    held_sum = sum;
    held_cout = cout;
    bad = 0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      a_i = W'($urandom); b_i = W'($urandom);
      @(negedge clk);
      if (sum !== held_sum || cout !== held_cout) bad++;
      if (done === 1'b1) ndone++;
    end
    check("idle_hold_sum", 32'(sum), 32'h41);
    check("idle_hold_changes", 32'(bad), 32'd0);
    check("idle_no_done", 32'(ndone), 32'd0);

`ifdef SUB_EN
    do_op("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    do_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'hFF, 1'b0);
    do_op("sub_55_55", 8'h55, 8'h55, 1'b1, 8'h00, 1'b1);
    do_op("sub_then_add", 8'h10, 8'h01, 1'b0, 8'h11, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
